// File: rtl/sym_delay_cal_if.sv
// Bundle of symbol-stream, sweep-control and result signals exchanged between
// the delay calibrator (slave) and the logic that drives it (master).
interface sym_delay_cal_if #(
  parameter int LOG2_N_ACC = 8
) ();
  logic                            sym_clk_en;
  logic                            start;
  logic signed [17:0]              ref_sym;
  logic signed [17:0]              rx_sym;
  logic [7:0]                      delay_out;
  logic                            busy;
  logic                            done;
  logic [7:0]                      best_delay;
  logic signed [18+LOG2_N_ACC-1:0] best_metric;

  modport master (
    output sym_clk_en, start, ref_sym, rx_sym,
    input  delay_out, busy, done, best_delay, best_metric
  );

  modport slave (
    input  sym_clk_en, start, ref_sym, rx_sym,
    output delay_out, busy, done, best_delay, best_metric
  );
endinterface

// File: rtl/sym_delay_cal.sv
// Sweeps a symbol delay line over 0..MAX_DELAY, correlates its output against the
// received stream at each setting and reports the delay with the largest correlation.
module sym_delay_cal #(
  parameter int MAX_DELAY   = 255,
  parameter int SETTLE_SYMS = 2,
  parameter int LOG2_N_ACC  = 8
) (
  input  logic           clk,
  input  logic           reset,
  sym_delay_cal_if.slave bus
);

  localparam int ACC_W = 18 + LOG2_N_ACC;
  localparam int SET_W = (SETTLE_SYMS > 1) ? $clog2(SETTLE_SYMS) : 1;
  localparam logic [SET_W-1:0]        SETTLE_LAST = SET_W'((SETTLE_SYMS > 0) ? SETTLE_SYMS - 1 : 0);
  localparam logic [LOG2_N_ACC-1:0]   ACC_LAST    = '1;
  localparam logic [7:0]              DELAY_LAST  = 8'(MAX_DELAY);
  localparam logic signed [ACC_W-1:0] METRIC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    COMPARE,
    FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              delay_q, delay_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SET_W-1:0]        settle_cnt_q, settle_cnt_d;
  logic [LOG2_N_ACC-1:0]   acc_cnt_q, acc_cnt_d;
  logic signed [ACC_W-1:0] run_metric_q, run_metric_d;
  logic [7:0]              run_delay_q, run_delay_d;
  logic [7:0]              best_delay_q, best_delay_d;
  logic signed [ACC_W-1:0] best_metric_q, best_metric_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic signed [17:0]      sym_term;

  // Full 36-bit product, keeping bits [34:17] as the per-symbol contribution
  assign sym_term = 18'(($signed({{18{bus.ref_sym[17]}}, bus.ref_sym}) *
                         $signed({{18{bus.rx_sym[17]}}, bus.rx_sym})) >>> 17);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      delay_q       <= '0;
      acc_q         <= '0;
      settle_cnt_q  <= '0;
      acc_cnt_q     <= '0;
      run_metric_q  <= '0;
      run_delay_q   <= '0;
      best_delay_q  <= '0;
      best_metric_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      delay_q       <= delay_d;
      acc_q         <= acc_d;
      settle_cnt_q  <= settle_cnt_d;
      acc_cnt_q     <= acc_cnt_d;
      run_metric_q  <= run_metric_d;
      run_delay_q   <= run_delay_d;
      best_delay_q  <= best_delay_d;
      best_metric_q <= best_metric_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    acc_d         = acc_q;
    settle_cnt_d  = settle_cnt_q;
    acc_cnt_d     = acc_cnt_q;
    run_metric_d  = run_metric_q;
    run_delay_d   = run_delay_q;
    best_delay_d  = best_delay_q;
    best_metric_d = best_metric_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          delay_d      = '0;
          acc_d        = '0;
          settle_cnt_d = '0;
          acc_cnt_d    = '0;
          run_metric_d = METRIC_MIN;
          run_delay_d  = '0;
          busy_d       = 1'b1;
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        if (SETTLE_SYMS == 0) begin
          state_d = ACCUM;
        end else if (bus.sym_clk_en) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            state_d      = ACCUM;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
      end

      ACCUM: begin
        if (bus.sym_clk_en) begin
          acc_d = acc_q + {{(ACC_W-18){sym_term[17]}}, sym_term};
          if (acc_cnt_q == ACC_LAST) begin
            acc_cnt_d = '0;
            state_d   = COMPARE;
          end else begin
            acc_cnt_d = acc_cnt_q + 1'b1;
          end
        end
      end

      // Strict greater-than keeps the smaller delay on ties
      COMPARE: begin
        if (acc_q > run_metric_q) begin
          run_metric_d = acc_q;
          run_delay_d  = delay_q;
        end
        if (delay_q == DELAY_LAST) begin
          state_d = FINISH;
        end else begin
          delay_d      = delay_q + 8'd1;
          acc_d        = '0;
          settle_cnt_d = '0;
          acc_cnt_d    = '0;
          state_d      = SETTLE;
        end
      end

      FINISH: begin
        best_delay_d  = run_delay_q;
        best_metric_d = run_metric_q;
        delay_d       = run_delay_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.delay_out   = delay_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.best_delay  = best_delay_q;
  assign bus.best_metric = best_metric_q;

endmodule

// File: tb/tb_sym_delay_cal.sv
// Directed bench for sym_delay_cal: four parameterisations share one PRBS15 source,
// each with its own modelled delay line feeding ref_sym from its delay_out.
module tb_sym_delay_cal;

  localparam logic signed [17:0] SYM_POS = 18'sh10000;
  localparam logic signed [17:0] SYM_NEG = 18'sh30000;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        hist [0:1023];
  logic [14:0] lfsr = 15'h0001;
  int          sym_idx    = 0;
  int          cyc        = 0;
  int          sym_period = 1;
  int          rx_mode    = 0;
  int          checks     = 0;
  int          errors     = 0;
  int          start_cyc  = 0;
  int          done_cnt [4];
  int          done_cyc [4];

  always #5 clk = ~clk;

  sym_delay_cal_if #(.LOG2_N_ACC(8)) def_if ();
  sym_delay_cal_if #(.LOG2_N_ACC(4)) sml_if ();
  sym_delay_cal_if #(.LOG2_N_ACC(8)) inv_if ();
  sym_delay_cal_if #(.LOG2_N_ACC(2)) tny_if ();

  sym_delay_cal u_def (.clk(clk), .reset(reset), .bus(def_if.slave));
  sym_delay_cal #(.MAX_DELAY(63), .SETTLE_SYMS(2), .LOG2_N_ACC(4)) u_sml (.clk(clk), .reset(reset), .bus(sml_if.slave));
  sym_delay_cal #(.MAX_DELAY(7)) u_inv (.clk(clk), .reset(reset), .bus(inv_if.slave));
  sym_delay_cal #(.MAX_DELAY(0), .SETTLE_SYMS(0), .LOG2_N_ACC(2)) u_tny (.clk(clk), .reset(reset), .bus(tny_if.slave));

  function automatic logic signed [17:0] sym_at(input int idx);
    return hist[10'(idx)] ? SYM_POS : SYM_NEG;
  endfunction

  // rx_mode 0: silence, 1: source delayed 5 symbols, 2: inverted source delayed 3
  function automatic logic signed [17:0] rx_at(input int idx);
    case (rx_mode)
      1:       return sym_at(idx - 5);
      2:       return hist[10'(idx - 3)] ? SYM_NEG : SYM_POS;
      default: return 18'sd0;
    endcase
  endfunction

  task automatic pushSym();
    sym_idx++;
    hist[10'(sym_idx)] = lfsr[14];
    lfsr = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
  endtask

  task automatic driveAll(input logic en);
    def_if.sym_clk_en = en;
    def_if.ref_sym    = sym_at(sym_idx - int'(def_if.delay_out));
    def_if.rx_sym     = rx_at(sym_idx);
    sml_if.sym_clk_en = en;
    sml_if.ref_sym    = sym_at(sym_idx - int'(sml_if.delay_out));
    sml_if.rx_sym     = rx_at(sym_idx);
    inv_if.sym_clk_en = en;
    inv_if.ref_sym    = sym_at(sym_idx - int'(inv_if.delay_out));
    inv_if.rx_sym     = rx_at(sym_idx);
    tny_if.sym_clk_en = en;
    tny_if.ref_sym    = sym_at(sym_idx - int'(tny_if.delay_out));
    tny_if.rx_sym     = rx_at(sym_idx);
  endtask

  task automatic clearDone();
    foreach (done_cnt[k]) begin
      done_cnt[k] = 0;
      done_cyc[k] = 0;
    end
  endtask

  // Each tick samples outputs on the falling edge, then presents the next symbol
  task automatic applyStimulus(input int n_clks);
    for (int i = 0; i < n_clks; i++) begin
      logic en;
      @(negedge clk);
      cyc++;
      if (def_if.done === 1'b1) begin done_cnt[0]++; done_cyc[0] = cyc; end
      if (sml_if.done === 1'b1) begin done_cnt[1]++; done_cyc[1] = cyc; end
      if (inv_if.done === 1'b1) begin done_cnt[2]++; done_cyc[2] = cyc; end
      if (tny_if.done === 1'b1) begin done_cnt[3]++; done_cyc[3] = cyc; end
      en = ((cyc % sym_period) == 0);
      if (en) pushSym();
      driveAll(en);
    end
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitDone(input int k, input int budget, input string tag);
    int n = 0;
    while (done_cnt[k] == 0 && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checks++;
    assert (done_cnt[k] > 0) else begin
      errors++;
      $error("[TB] FAIL %s: observed done count %0d expected 1 within %0d clks", tag, done_cnt[k], budget);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 300; i++) pushSym();
    def_if.start = 1'b0;
    sml_if.start = 1'b0;
    inv_if.start = 1'b0;
    tny_if.start = 1'b0;
    driveAll(1'b0);
    clearDone();

    applyStimulus(3);
    checkOutput("reset_delay_out", def_if.delay_out, 0);
    checkOutput("reset_busy", def_if.busy, 0);
    checkOutput("reset_done", def_if.done, 0);
    checkOutput("reset_best_delay", def_if.best_delay, 0);
    checkOutput("reset_best_metric", def_if.best_metric, 0);
    reset = 1'b0;
    applyStimulus(2);

    // Default parameters: rx is the reference delayed by 5 symbols
    rx_mode = 1;
    sym_period = 1;
    clearDone();
    def_if.start = 1'b1;
    start_cyc = cyc;
    applyStimulus(1);
    def_if.start = 1'b0;
    checkOutput("def_busy_after_start", def_if.busy, 1);
    checkOutput("def_delay_after_start", def_if.delay_out, 0);
    waitDone(0, 70000, "def_done");
    checkOutput("def_latency", done_cyc[0] - start_cyc, 66306);
    checkOutput("def_best_delay", def_if.best_delay, 5);
    checkOutput("def_best_metric", def_if.best_metric, 64'sh800000);
    checkOutput("def_delay_out", def_if.delay_out, 5);
    checkOutput("def_busy_low", def_if.busy, 0);
    applyStimulus(1);
    checkOutput("def_done_one_clk", def_if.done, 0);
    applyStimulus(20);
    checkOutput("def_hold_delay", def_if.delay_out, 5);
    checkOutput("def_done_count", done_cnt[0], 1);

    // Small sweep with gapped symbol enables, uninterrupted
    sym_period = 2;
    clearDone();
    sml_if.start = 1'b1;
    applyStimulus(1);
    sml_if.start = 1'b0;
    waitDone(1, 5000, "sml_done");
    checkOutput("sml_best_delay", sml_if.best_delay, 5);
    checkOutput("sml_best_metric", sml_if.best_metric, 64'sh80000);
    checkOutput("sml_delay_out", sml_if.delay_out, 5);
    applyStimulus(3);

    // Silent rx: every metric is zero, the tie rule keeps delay 0
    rx_mode = 0;
    clearDone();
    sml_if.start = 1'b1;
    applyStimulus(1);
    sml_if.start = 1'b0;
    waitDone(1, 5000, "zero_done");
    checkOutput("zero_best_delay", sml_if.best_delay, 0);
    checkOutput("zero_best_metric", sml_if.best_metric, 0);
    checkOutput("zero_delay_out", sml_if.delay_out, 0);
    applyStimulus(3);

    // Start re-asserted mid-sweep must not rewind the sweep
    rx_mode = 1;
    clearDone();
    sml_if.start = 1'b1;
    applyStimulus(1);
    sml_if.start = 1'b0;
    applyStimulus(400);
    sml_if.start = 1'b1;
    applyStimulus(5);
    sml_if.start = 1'b0;
    checkOutput("restart_busy", sml_if.busy, 1);
    checkOutput("restart_no_rewind", (sml_if.delay_out >= 8'd8), 1);
    waitDone(1, 5000, "restart_done");
    checkOutput("restart_best_delay", sml_if.best_delay, 5);
    checkOutput("restart_best_metric", sml_if.best_metric, 64'sh80000);
    applyStimulus(50);
    checkOutput("restart_done_count", done_cnt[1], 1);

    // Inverted rx at delay 3: the strongly negative metric must lose
    rx_mode = 2;
    sym_period = 1;
    clearDone();
    inv_if.start = 1'b1;
    start_cyc = cyc;
    applyStimulus(1);
    inv_if.start = 1'b0;
    waitDone(2, 3000, "inv_done");
    checkOutput("inv_latency", done_cyc[2] - start_cyc, 2074);
    checkOutput("inv_not_delay3", (inv_if.best_delay != 8'd3), 1);
    checkOutput("inv_metric_above_min", (inv_if.best_metric > -26'sd8388608), 1);
    applyStimulus(5);
    checkOutput("inv_done_count", done_cnt[2], 1);

    // Asynchronous reset while accumulating at delay 40
    rx_mode = 1;
    sym_period = 2;
    clearDone();
    sml_if.start = 1'b1;
    applyStimulus(1);
    sml_if.start = 1'b0;
    n = 0;
    while (sml_if.delay_out != 8'd40 && n < 3000) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("rst_reached_delay40", sml_if.delay_out, 40);
    applyStimulus(12);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_delay_out", sml_if.delay_out, 0);
    checkOutput("rst_busy", sml_if.busy, 0);
    checkOutput("rst_done", sml_if.done, 0);
    checkOutput("rst_best_delay", sml_if.best_delay, 0);
    checkOutput("rst_best_metric", sml_if.best_metric, 0);
    applyStimulus(2);
    reset = 1'b0;
    sml_if.start = 1'b1;
    applyStimulus(1);
    sml_if.start = 1'b0;
    checkOutput("rst_no_done", done_cnt[1], 0);
    checkOutput("rst_start_accepted", sml_if.busy, 1);
    waitDone(1, 5000, "rst_resweep_done");
    checkOutput("rst_best_delay_after", sml_if.best_delay, 5);
    checkOutput("rst_best_metric_after", sml_if.best_metric, 64'sh80000);

    // Degenerate sweep: one delay, no settling, four symbols
    sym_period = 1;
    clearDone();
    tny_if.start = 1'b1;
    start_cyc = cyc;
    applyStimulus(1);
    tny_if.start = 1'b0;
    waitDone(3, 50, "tny_done");
    checkOutput("tny_latency", done_cyc[3] - start_cyc, 8);
    checkOutput("tny_best_delay", tny_if.best_delay, 0);
    applyStimulus(1);
    checkOutput("tny_done_one_clk", tny_if.done, 0);
    checkOutput("tny_done_count", done_cnt[3], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_delay_cal.md
SYM_DELAY_CAL -- requirements
Module: sym_delay_cal

Interface
REQ-001 The block SHALL have parameter MAX_DELAY, default 255, meaning the last delay value swept (0..255).
REQ-002 The block SHALL have parameter SETTLE_SYMS, default 2, meaning the symbols discarded after each delay change before accumulation starts.
REQ-003 The block SHALL have parameter LOG2_N_ACC, default 8, meaning the accumulation length per delay is 2^LOG2_N_ACC symbols.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port sym_clk_en, input, 1 bit: symbol-rate enable, one clk wide.
REQ-007 The block SHALL have port start, input, 1 bit: request for a calibration sweep.
REQ-008 The block SHALL have port ref_sym, input, signed 18 bits: output of the configurable symbol delay line driven by delay_out.
REQ-009 The block SHALL have port rx_sym, input, signed 18 bits: received symbol stream.
REQ-010 The block SHALL have port delay_out, output, 8 bits: delay select driven into the delay line.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-clk pulse when a sweep completes.
REQ-013 The block SHALL have port best_delay, output, 8 bits: the winning delay from the last completed sweep.
REQ-014 The block SHALL have port best_metric, output, signed 18+LOG2_N_ACC bits: the correlation at best_delay.

Function
REQ-015 The block SHALL use the states IDLE, SETTLE, ACCUM, COMPARE and FINISH.
REQ-016 In IDLE, start=1 SHALL cause the following on the next clk: delay_out=0, accumulator=0, running best metric=most-negative value, running best delay=0, state=SETTLE, busy=1.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 SETTLE SHALL count sym_clk_en pulses and, after SETTLE_SYMS of them, move to ACCUM on the same clk as the last pulse.
REQ-019 SETTLE_SYMS=0 SHALL mean going directly to ACCUM on the clk after entering SETTLE.
REQ-020 ACCUM SHALL act on each sym_clk_en: product = ref_sym*rx_sym (36-bit signed), and the accumulator adds the sign-extended product[34:17].
REQ-021 ACCUM SHALL ignore clks without sym_clk_en.
REQ-022 After 2^LOG2_N_ACC accumulated symbols, ACCUM SHALL go to COMPARE.
REQ-023 The accumulator width SHALL be 18+LOG2_N_ACC bits with no saturation; the width guarantees no overflow.
REQ-024 COMPARE SHALL take exactly one clk.
REQ-025 In COMPARE, if accumulator > running best (strictly greater; ties keep the earlier, smaller delay), best metric and best delay SHALL be updated.
REQ-026 In COMPARE with delay_out < MAX_DELAY: delay_out SHALL increment by 1, the accumulator SHALL clear, and the state SHALL return to SETTLE.
REQ-027 In COMPARE with delay_out == MAX_DELAY: the state SHALL go to FINISH, with no increment and no wrap to 0.
REQ-028 FINISH SHALL take one clk: best_delay/best_metric outputs load the running best, delay_out=running best delay, done=1, busy=0, then the state returns to IDLE.
REQ-029 best_delay, best_metric and delay_out SHALL hold their values in IDLE until the next sweep starts.
REQ-030 done SHALL be registered and high for exactly one clk per sweep.
REQ-031 Sweep latency in symbols SHALL be (MAX_DELAY+1)*(SETTLE_SYMS+2^LOG2_N_ACC), plus one clk per delay for COMPARE and one clk for FINISH.
REQ-032 A sym_clk_en that coincides with a COMPARE clk SHALL be dropped and SHALL NOT be counted by the next SETTLE.

Reset
REQ-033 Asserting reset SHALL asynchronously force: state=IDLE, delay_out=0, busy=0, done=0, best_delay=0, best_metric=0, and all counters and the accumulator to 0.
REQ-034 Reset mid-sweep SHALL abort the sweep with no done pulse; the block SHALL accept start on the first clk after reset deasserts.

Verification
REQ-035 Bench SHALL cover: rx_sym = ref PRBS ±0x10000 delayed 5 symbols, defaults -> done once, best_delay=5, best_metric=256*0x8000=0x800000, delay_out=5.
REQ-036 Bench SHALL cover: rx_sym=0 throughout -> all metrics 0, tie rule gives best_delay=0, best_metric=0.
REQ-037 Bench SHALL cover: rx_sym inverted (−ref) at delay 3, MAX_DELAY=7 -> best_delay is not 3, and the metric at delay 3 = −0x800000 is never selected.
REQ-038 Bench SHALL cover: start pulsed again mid-sweep -> no restart, single done, result unchanged versus the uninterrupted run.
REQ-039 Bench SHALL cover: reset asserted during ACCUM at delay 40 -> outputs 0 immediately, no done; a new start then completes the correct sweep.
REQ-040 Bench SHALL cover: MAX_DELAY=0, SETTLE_SYMS=0, LOG2_N_ACC=2 -> done after 4 symbols+2 clks, best_delay=0.
